// File: rtl/bar_pkg.sv
// Shared definitions for the bar valid/ready stream: data width, data type, generator states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bar_pkg;

  localparam int BAR_DW = 32;

  typedef logic [BAR_DW-1:0] bar_data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP_WAIT = 2'd2,
    DONE     = 2'd3
  } bar_gen_state_e;

endpackage

// File: rtl/bar_if.sv
// bar valid/ready stream: one data word per beat, transferred when valid && ready at a rising edge.
// Latency: n/a (wires only).
// Backpressure: consumer holds ready low; producer keeps valid and data stable until accepted.
interface bar;
  import bar_pkg::*;

  bar_data_t data;
  logic      valid;
  logic      ready;

  modport out (output data, output valid, input ready);
  modport in  (input data, input valid, output ready);
endinterface

// File: rtl/bar_stream_gen.sv
// Burst source: emits base, base+step, ... for len beats on a bar.out stream, with optional idle gap.
// Latency: first valid 1 cycle after accepted start; done pulses the cycle after the last accepted beat.
// Backpressure: data/valid held while ready is low; valid never withdrawn before acceptance.
module bar_stream_gen
  import bar_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [31:0]      step,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sent,
  bar.out                  y
);

  // Gap counter only needs to hold GAP; keep at least one bit so GAP=0 still elaborates.
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  bar_gen_state_e   state_q, state_d;
  bar_data_t        data_q, data_d;
  bar_data_t        step_q, step_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: valid is registered, so in SEND acceptance reduces to y.ready.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    step_d  = step_q;
    len_d   = len_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          sent_d = '0;
          if (len != '0) begin
            data_d  = base;
            step_d  = step;
            len_d   = len;
            valid_d = 1'b1;
            state_d = SEND;
          end else begin
            // Empty burst: straight to completion, nothing is driven on the stream.
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (y.ready) begin
          sent_d = sent_q + LEN_W'(1);
          if (sent_q == len_q - LEN_W'(1)) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            data_d = data_q + step_q;
            if (GAP != 0) begin
              valid_d = 1'b0;
              gap_d   = GW'(GAP);
              state_d = GAP_WAIT;
            end
          end
        end
      end
      GAP_WAIT: begin
        // Raising valid on the count of 1 gives exactly GAP idle cycles.
        if (gap_q == GW'(1)) begin
          valid_d = 1'b1;
          state_d = SEND;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      step_q  <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      step_q  <= step_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y.data  = data_q;
  assign y.valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sent    = sent_q;

endmodule

// File: tb/tb_bar_stream_gen.sv
// Self-checking bench for bar_stream_gen: back-to-back instance plus a GAP=2 instance.
// Latency: checks first-valid and done timing against start.
// Backpressure: stalls ready and checks data/valid stay stable.
module tb_bar_stream_gen;

  logic        clk;
  logic        rst_n;
  logic        start0, start2;
  logic [31:0] base, step;
  logic [15:0] len;
  logic        busy0, done0, busy2, done2;
  logic [15:0] sent0, sent2;

  bar y0 ();
  bar y2 ();

  logic [31:0] q0[$];
  logic [31:0] q2[$];

  int n_chk  = 0;
  int n_pass = 0;
  int dones0 = 0;
  int beats0 = 0;

  bar_stream_gen #(.LEN_W(16), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base(base), .step(step), .len(len),
    .busy(busy0), .done(done0), .sent(sent0), .y(y0)
  );

  bar_stream_gen #(.LEN_W(16), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base(base), .step(step), .len(len),
    .busy(busy2), .done(done2), .sent(sent2), .y(y2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Drive a start pulse and queue the expected words for the chosen instance.
  task automatic go(input bit sel, input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
    @(posedge clk); #1;
    base = b; step = s; len = l;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      if (sel) q2.push_back(b + s * 32'(i));
      else     q0.push_back(b + s * 32'(i));
    end
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? done2 : done0) && cyc < 200);
    if (!(sel ? done2 : done0)) chk("done_timeout", 32'(cyc), 32'd0);
  endtask

  // Scoreboard/monitor for the GAP=0 instance.
  initial begin
    logic        stall;
    logic [31:0] stall_dat;
    logic [31:0] exp;
    stall = 1'b0;
    stall_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_vld", 32'(y0.valid), 32'd1);
          chk("hold_dat", y0.data, stall_dat);
        end
        if (y0.valid && y0.ready) begin
          if (q0.size() == 0) chk("extra_beat", 32'(q0.size()), 32'd1);
          else begin
            exp = q0.pop_front();
            chk("beat_dat", y0.data, exp);
            beats0++;
          end
        end
        stall = y0.valid && !y0.ready;
        stall_dat = y0.data;
        if (done0) dones0++;
      end
    end
  end

  // Scoreboard/monitor for the GAP=2 instance, including idle-gap length.
  initial begin
    bit          seen;
    int          idle;
    logic [31:0] exp;
    seen = 1'b0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else begin
        if (y2.valid && y2.ready) begin
          if (q2.size() == 0) chk("gap_extra_beat", 32'(q2.size()), 32'd1);
          else begin
            exp = q2.pop_front();
            chk("gap_dat", y2.data, exp);
          end
          if (seen) chk("gap_idle", 32'(idle), 32'd2);
          seen = 1'b1;
          idle = 0;
        end else if (seen && !y2.valid) begin
          idle++;
        end
        if (done2) seen = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    int d_before;
    int b_before;
    rst_n = 1'b0;
    start0 = 1'b0; start2 = 1'b0;
    base = '0; step = '0; len = '0;
    y0.ready = 1'b1;
    y2.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(y0.valid), 32'd0);
    chk("rst_dat", y0.data, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_sent", 32'(sent0), 32'd0);
    rst_n = 1'b1;

    // Back-to-back burst.
    go(1'b0, 32'h10, 32'd4, 16'd4);
    chk("b2b_first_vld", 32'(y0.valid), 32'd1);
    chk("b2b_first_dat", y0.data, 32'h10);
    chk("b2b_busy", 32'(busy0), 32'd1);
    wait_done(1'b0, cyc);
    chk("b2b_done_lat", 32'(cyc), 32'd5);
    chk("b2b_sent", 32'(sent0), 32'd4);
    chk("b2b_busy_at_done", 32'(busy0), 32'd1);
    chk("b2b_q_empty", 32'(q0.size()), 32'd0);
    @(posedge clk); #1;
    chk("b2b_done_drop", 32'(done0), 32'd0);
    chk("b2b_busy_drop", 32'(busy0), 32'd0);
    chk("b2b_sent_keep", 32'(sent0), 32'd4);

    // Backpressure on beat 2 for 3 cycles.
    go(1'b0, 32'hA, 32'd1, 16'd3);
    @(posedge clk); #1;
    y0.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stalled_dat", y0.data, 32'hB);
    chk("bp_stalled_sent", 32'(sent0), 32'd1);
    y0.ready = 1'b1;
    wait_done(1'b0, cyc);
    chk("bp_sent", 32'(sent0), 32'd3);
    chk("bp_q_empty", 32'(q0.size()), 32'd0);

    // Empty burst.
    @(posedge clk);
    go(1'b0, 32'h55, 32'd1, 16'd0);
    chk("len0_vld", 32'(y0.valid), 32'd0);
    chk("len0_done", 32'(done0), 32'd1);
    chk("len0_busy", 32'(busy0), 32'd1);
    chk("len0_sent", 32'(sent0), 32'd0);
    wait_done(1'b0, cyc);
    chk("len0_lat", 32'(cyc), 32'd1);
    @(posedge clk); #1;
    chk("len0_done_drop", 32'(done0), 32'd0);
    chk("len0_busy_drop", 32'(busy0), 32'd0);

    // Start while busy is ignored.
    d_before = dones0;
    b_before = beats0;
    go(1'b0, 32'h100, 32'd3, 16'd5);
    @(posedge clk); #1;
    base = 32'h999; len = 16'd2; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(1'b0, cyc);
    repeat (5) @(negedge clk);
    chk("sdb_dones", 32'(dones0 - d_before), 32'd1);
    chk("sdb_beats", 32'(beats0 - b_before), 32'd5);
    chk("sdb_sent", 32'(sent0), 32'd5);
    chk("sdb_q_empty", 32'(q0.size()), 32'd0);

    // Wrap and gap on the GAP=2 instance.
    go(1'b1, 32'hFFFF_FFFE, 32'd1, 16'd3);
    wait_done(1'b1, cyc);
    chk("gap_done_lat", 32'(cyc), 32'd8);
    chk("gap_sent", 32'(sent2), 32'd3);
    chk("gap_q_empty", 32'(q2.size()), 32'd0);

    // Reset in the middle of a burst.
    d_before = dones0;
    go(1'b0, 32'h200, 32'd1, 16'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_dat_before", y0.data, 32'h202);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(y0.valid), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_sent", 32'(sent0), 32'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_done", 32'(dones0 - d_before), 32'd0);
    go(1'b0, 32'h300, 32'd2, 16'd2);
    chk("post_first_dat", y0.data, 32'h300);
    wait_done(1'b0, cyc);
    chk("post_sent", 32'(sent0), 32'd2);
    chk("post_q_empty", 32'(q0.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
